// File: rtl/dti_uart_pkg.sv
// Shared types and helpers for the dti_uart receive path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dti_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Widest data word the parity helper accepts; callers zero-extend.
    localparam int PARITY_MAX_W = 16;

    // cfg_data_bit_num 00/01/10/11 -> 5/6/7/8 data bits
    function automatic logic [3:0] data_bits(input logic [1:0] sel);
        return 4'd5 + 4'(sel);
    endfunction

    // Expected parity bit: even parity makes the total XOR zero, odd inverts it.
    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_calc(input logic [PARITY_MAX_W-1:0] dat, input logic odd);
        return (^dat) ^ odd;
    endfunction

endpackage

// File: rtl/dti_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; head data is 0 while empty.
// Latency: a write into an empty FIFO is visible on rd_dat one clk later.
// Backpressure: wr_rdy drops when full unless a read fires in the same cycle.
module dti_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             wr_fire, rd_fire, full;

    assign rd_vld  = (level_q != '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign rd_fire = rd_vld & rd_rdy;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_rdy  = ~full | rd_fire;
    assign wr_fire = wr_vld & wr_rdy;
    assign rd_dat  = rd_vld ? mem[rd_ptr_q] : '0;
    assign level   = level_q;

    // Storage array, no reset needed: contents are masked while empty.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= wr_dat;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: oversampled majority-vote bit recovery, error/break detection, RX FIFO + RTS.
// Latency: entry pushed at mid of last stop bit; head visible 1 clk later.
// Backpressure: rts_n asks the sender to stop near full; words arriving when full are dropped (err_overrun).
module uart_rx_fifo
    import dti_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    input  logic                          clken,
    input  logic [1:0]                    cfg_data_bit_num,
    input  logic                          cfg_stop_bit_num,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_type,
    input  logic                          host_rd_en,
    input  logic                          err_clear,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_err_parity,
    output logic                          rx_err_frame,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rts_n,
    output logic                          err_overrun,
    output logic                          stt_break
);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int EW  = DATA_WIDTH + 2;

    rx_state_e             state_q, state_d;
    logic                  rx_meta, rxs, rxs_prev;
    logic [SW-1:0]         sample_q;
    logic [2:0]            bit_cnt_q;
    logic                  v0_q, v1_q, par_vote_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  perr_q, ferr_q, brk_q;
    logic [1:0]            sh_dbits;
    logic                  sh_stop2, sh_par_en, sh_par_type;
    logic                  fall, at_mid_m1, at_mid, at_vote, at_end, vote;
    logic                  last_data, last_stop, brk_now, start_frame;
    logic [3:0]            nbits;
    logic                  push, push_brk, stop_ferr;
    logic                  fifo_wr_rdy, pop;
    logic [EW-1:0]         head_dat;

    assign fall        = clken & rxs_prev & ~rxs;
    assign at_mid_m1   = clken & (sample_q == SW'(MID - 1));
    assign at_mid      = clken & (sample_q == SW'(MID));
    assign at_vote     = clken & (sample_q == SW'(MID + 1));
    assign at_end      = clken & (sample_q == SW'(OVERSAMPLE - 1));
    assign vote        = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
    assign nbits       = data_bits(sh_dbits);
    assign last_data   = ({1'b0, bit_cnt_q} == (nbits - 4'd1));
    assign last_stop   = (bit_cnt_q == {2'b00, sh_stop2});
    assign start_frame = (state_q == IDLE) & fall;
    // Break: all-zero data, zero parity bit (if present), and a zero first stop bit.
    assign brk_now     = (shift_q == '0) & (~sh_par_en | ~par_vote_q) & ~vote;

    // Two-flop synchroniser; edge history advances on oversample ticks only.
    // Line is assumed idle (high) out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            if (clken) rxs_prev <= rxs;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state: all moves happen on clken-qualified sample points.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall) state_d = START;
            START:   if (at_vote && vote) state_d = IDLE;
                     else if (at_end)     state_d = DATA;
            DATA:    if (at_end && last_data) state_d = sh_par_en ? PARITY : STOP;
            PARITY:  if (at_end) state_d = STOP;
            STOP:    if (at_vote && last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: push happens half way through the last stop bit to leave resync margin.
    always_comb begin
        push      = 1'b0;
        push_brk  = 1'b0;
        stop_ferr = ferr_q;
        if (state_q == STOP && at_vote) begin
            stop_ferr = ferr_q | ~vote;
            if (last_stop) begin
                push     = 1'b1;
                push_brk = brk_q | ((bit_cnt_q == 3'd0) & brk_now);
            end
        end
    end

    // Sample/bit counters, vote samples, shift register, per-frame errors and cfg shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q    <= '0;
            bit_cnt_q   <= '0;
            v0_q        <= 1'b1;
            v1_q        <= 1'b1;
            par_vote_q  <= 1'b0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            sh_dbits    <= 2'b11;
            sh_stop2    <= 1'b0;
            sh_par_en   <= 1'b0;
            sh_par_type <= 1'b0;
        end else begin
            if (clken) begin
                if (state_q == IDLE || state_d == IDLE)      sample_q <= '0;
                else if (sample_q == SW'(OVERSAMPLE - 1))    sample_q <= '0;
                else                                         sample_q <= sample_q + SW'(1);
            end
            if (at_mid_m1) v0_q <= rxs;
            if (at_mid)    v1_q <= rxs;

            if (state_q == IDLE) begin
                bit_cnt_q <= '0;
            end else if (at_end) begin
                if ((state_q == DATA && !last_data) || state_q == STOP) bit_cnt_q <= bit_cnt_q + 3'd1;
                else                                                    bit_cnt_q <= '0;
            end

            if (start_frame) begin
                shift_q     <= '0;
                perr_q      <= 1'b0;
                ferr_q      <= 1'b0;
                brk_q       <= 1'b0;
                sh_dbits    <= cfg_data_bit_num;
                sh_stop2    <= cfg_stop_bit_num;
                sh_par_en   <= cfg_parity_en;
                sh_par_type <= cfg_parity_type;
            end
            if (state_q == DATA && at_vote) shift_q[bit_cnt_q] <= vote;
            if (state_q == PARITY && at_vote) begin
                par_vote_q <= vote;
                perr_q     <= vote ^ parity_calc(PARITY_MAX_W'(shift_q), sh_par_type);
            end
            if (state_q == STOP && at_vote) begin
                ferr_q <= stop_ferr;
                if (bit_cnt_q == 3'd0) brk_q <= brk_now;
            end
        end
    end

    assign pop = host_rd_en & rx_valid;

    dti_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (push),
        .wr_dat  ({stop_ferr, perr_q, shift_q}),
        .wr_rdy  (fifo_wr_rdy),
        .rd_vld  (rx_valid),
        .rd_dat  (head_dat),
        .rd_rdy  (host_rd_en),
        .level   (rx_level)
    );

    assign {rx_err_frame, rx_err_parity, rx_data} = head_dat;

    // Sticky flags (a new event beats a simultaneous clear) and registered RTS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overrun <= 1'b0;
            stt_break   <= 1'b0;
            rts_n       <= 1'b0;
        end else begin
            err_overrun <= (push & ~fifo_wr_rdy) | (err_overrun & ~err_clear);
            stt_break   <= (push & push_brk)     | (stt_break & ~err_clear);
            rts_n       <= ((LW'(FIFO_DEPTH) - rx_level) <= LW'(RTS_MARGIN));
        end
    end

endmodule
